// File: rtl/operand_queue.sv
// Operand queue: an in-order operand store with multi-entry consume and append.
// Slot 0 always holds the oldest operand; the valid bits form a thermometer code starting at slot 0.
module operand_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   put_en,
    input  logic [WIDTH-1:0]       put_value,
    input  logic                   op_en,
    input  logic [CW-1:0]          op_count,
    input  logic                   clear,
    output logic [DEPTH*WIDTH-1:0] slot_data,
    output logic [DEPTH-1:0]       slot_valid,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   op_ready,
    output logic                   overflow,
    output logic                   op_err
);

    typedef logic [DEPTH-1:0][WIDTH-1:0] slots_t;

    slots_t           slots_q, slots_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             op_err_q, op_err_d;
    logic             accept;

    assign op_ready = (op_count <= count_q);
    assign accept   = op_en && op_ready;

    always_comb begin
        slots_d    = slots_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        op_err_d   = 1'b0;
        if (clear) begin
            slots_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            op_err_d = op_en && !accept;
            // Pop first so a put in the same cycle lands behind the survivors.
            if (accept) begin
                for (int i = 0; i < DEPTH; i++) begin
                    slots_d[i] = '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j == i + int'(op_count)) slots_d[i] = slots_q[j];
                    end
                end
                count_d = count_q - op_count;
            end
            if (put_en) begin
                if (int'(count_d) < DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == int'(count_d)) slots_d[i] = put_value;
                    end
                    count_d = count_d + CW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = (i < int'(count_d));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slots_q    <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            slots_q    <= slots_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            op_err_q   <= op_err_d;
        end
    end

    assign slot_data  = slots_q;
    assign slot_valid = valid_q;
    assign count      = count_q;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign overflow   = overflow_q;
    assign op_err     = op_err_q;

endmodule

// File: tb/tb_operand_queue.sv
// Scoreboard bench for operand_queue: a queue-based reference model predicts each cycle's
// state, and a monitor compares it against the registered outputs after every rising edge.
module tb_operand_queue;
    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          put_en, op_en, clear;
    logic [W-1:0]  put_value;
    logic [CW-1:0] op_count;
    logic [D*W-1:0] slot_data;
    logic [D-1:0]  slot_valid;
    logic [CW-1:0] count;
    logic          full, empty, op_ready, overflow, op_err;

    operand_queue #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
        .clk(clk), .reset(reset), .put_en(put_en), .put_value(put_value),
        .op_en(op_en), .op_count(op_count), .clear(clear),
        .slot_data(slot_data), .slot_valid(slot_valid), .count(count),
        .full(full), .empty(empty), .op_ready(op_ready),
        .overflow(overflow), .op_err(op_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [D*W-1:0] data;
        logic [D-1:0]   valid;
        logic [CW-1:0]  cnt;
        logic           ovf;
        logic           err;
    } exp_t;

    exp_t       exp_q[$];
    logic [W-1:0] mq[$];
    logic       movf;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t snapshot(input logic err);
        exp_t e;
        e = '0;
        for (int i = 0; i < mq.size(); i++) begin
            e.data[i*W +: W] = mq[i];
            e.valid[i]       = 1'b1;
        end
        e.cnt = CW'(mq.size());
        e.ovf = movf;
        e.err = err;
        return e;
    endfunction

    task automatic model(input logic p, input logic [W-1:0] v, input logic o,
                         input logic [CW-1:0] c, input logic cl);
        logic acc, err;
        err = 1'b0;
        if (cl) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            acc = o && (int'(c) <= mq.size());
            err = o && !acc;
            if (acc) repeat (int'(c)) void'(mq.pop_front());
            if (p) begin
                if (mq.size() < D) mq.push_back(v);
                else movf = 1'b1;
            end
        end
        exp_q.push_back(snapshot(err));
    endtask

    // One clock of stimulus; returns shortly after the edge that applies it.
    task automatic step(input logic p, input logic [W-1:0] v, input logic o,
                        input logic [CW-1:0] c, input logic cl);
        @(negedge clk);
        put_en = p; put_value = v; op_en = o; op_count = c; clear = cl;
        #1 chk("op_ready", 32'(op_ready), 32'(int'(c) <= mq.size()));
        model(p, v, o, c, cl);
        @(posedge clk);
        #2;
    endtask

    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_slot_data", 32'(slot_data), 32'(mon_e.data));
            chk("sb_slot_valid", 32'(slot_valid), 32'(mon_e.valid));
            chk("sb_count", 32'(count), 32'(mon_e.cnt));
            chk("sb_overflow", 32'(overflow), 32'(mon_e.ovf));
            chk("sb_op_err", 32'(op_err), 32'(mon_e.err));
            chk("sb_full", 32'(full), 32'(mon_e.cnt == CW'(D)));
            chk("sb_empty", 32'(empty), 32'(mon_e.cnt == '0));
            chk("inv_popcount", 32'(count), 32'($countones(slot_valid)));
        end
    end

    initial begin
        movf = 1'b0;
        reset = 1'b0;
        put_en = 1'b0; put_value = '0; op_en = 1'b0; op_count = '0; clear = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_data", 32'(slot_data), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Fill to full
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0);
        chk("fill_data", 32'(slot_data), 32'h332211);
        chk("fill_valid", 32'(slot_valid), 32'b111);
        chk("fill_count", 32'(count), 3);
        chk("fill_full", 32'(full), 1);

        // Dropped put, then pop-2 plus put while full
        step(1, 8'h44, 0, 0, 0);
        chk("drop_data", 32'(slot_data), 32'h332211);
        chk("drop_ovf", 32'(overflow), 1);
        step(1, 8'h55, 1, 2, 0);
        chk("popput_data", 32'(slot_data), 32'h005533);
        chk("popput_count", 32'(count), 2);
        chk("popput_ovf", 32'(overflow), 1);

        // Clear wins over put and op_en
        step(1, 8'h99, 1, 1, 1);
        chk("clr_count", 32'(count), 0);
        chk("clr_data", 32'(slot_data), 0);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_err", 32'(op_err), 0);

        // Rejected consume with count=1
        step(1, 8'h77, 0, 0, 0);
        step(0, 8'h00, 1, 3, 0);
        chk("rej_err", 32'(op_err), 1);
        chk("rej_count", 32'(count), 1);
        chk("rej_data", 32'(slot_data), 32'h000077);
        step(0, 8'h00, 0, 0, 0);
        chk("rej_err_pulse", 32'(op_err), 0);
        step(0, 8'h00, 1, 0, 0);
        chk("zero_op_err", 32'(op_err), 0);
        chk("zero_op_count", 32'(count), 1);

        // Put plus consume while full is accepted without overflow
        step(1, 8'h88, 0, 0, 0);
        step(1, 8'h99, 0, 0, 0);
        step(1, 8'hAA, 1, 1, 0);
        chk("fullpp_data", 32'(slot_data), 32'hAA9988);
        chk("fullpp_ovf", 32'(overflow), 0);

        // Reset between edges with count=3, put pending on release
        @(negedge clk);
        put_en = 1'b1; put_value = 8'hAB; op_en = 1'b0; op_count = '0; clear = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_data", 32'(slot_data), 0);
        chk("mid_rst_valid", 32'(slot_valid), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        mq.delete();
        movf = 1'b0;
        #1 reset = 1'b1;
        model(1, 8'hAB, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("post_rst_count", 32'(count), 1);
        chk("post_rst_data", 32'(slot_data), 32'h0000AB);

        // Random stream against the reference model
        for (int n = 0; n < 10000; n++) begin
            step(($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 40),
                 CW'($urandom_range(0, 3)), ($urandom_range(0, 99) < 3));
        end

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/operand_queue.md
OPERAND_QUEUE -- requirements
Module: operand_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 3, the number of operand slots; legal range is 2..16.
REQ-003 SHALL have parameter CW, default $clog2(DEPTH+1), the width of the count fields.
REQ-004 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 put_en  input  1  appends put_value this cycle.
REQ-007 put_value  input  WIDTH  the operand to append.
REQ-008 op_en  input  1  consumes op_count of the oldest operands this cycle.
REQ-009 op_count  input  CW  the number of operands to consume; the range is 0..DEPTH.
REQ-010 clear  input  1  synchronous flush of all slots.
REQ-011 slot_data  output  DEPTH*WIDTH  the registered slot contents; slot i occupies bits [i*WIDTH +: WIDTH]; slot 0 is the oldest.
REQ-012 slot_valid  output  DEPTH  the registered per-slot valid bits; always thermometer-coded from bit 0.
REQ-013 count  output  CW  the number of valid slots.
REQ-014 full, empty  output  1 each  full = (count==DEPTH); empty = (count==0).
REQ-015 op_ready  output  1  combinational; (op_count <= count).
REQ-016 overflow  output  1  sticky; set when a put is dropped.
REQ-017 op_err  output  1  one-cycle pulse when a consume is rejected.

Function
REQ-018 Outputs reflect state after the last edge; a put or consume becomes visible one cycle after the edge on which it is sampled.
REQ-019 Accepted consume: op_en=1 and op_count<=count -> slots shift down by op_count; slot_data of freed slots SHALL be 0; valid bits cleared from the top.
REQ-020 An op_en with op_count==0 SHALL be a no-op with no op_err.
REQ-021 A rejected consume (op_en=1, op_count>count) SHALL leave state unchanged, pulse op_err for one cycle, and still apply any put in the same cycle.
REQ-022 A put SHALL write put_value into slot index count_after_consume and set its valid bit.
REQ-023 Simultaneous put and accepted consume SHALL pop first, then append; new count = count - op_count + 1.
REQ-024 A put with full=1 and no accepted consume freeing a slot SHALL be dropped, leave the slots unchanged, and set overflow.
REQ-025 Simultaneous put and consume while full SHALL be accepted; overflow SHALL NOT be set.
REQ-026 clear SHALL take priority over put and op_en: it zeroes all slots, valid bits and count, clears overflow, and asserts no op_err.
REQ-027 overflow SHALL stay set until clear or reset.
REQ-028 count SHALL always equal popcount(slot_valid), and SHALL never exceed DEPTH or wrap.

Reset
REQ-029 reset low SHALL immediately force slot_data=0, slot_valid=0, count=0, overflow=0, op_err=0, empty=1, full=0, independent of clk.
REQ-030 On reset deassertion, the first state change SHALL occur on the next rising clk edge.
REQ-031 Reset asserted mid-operation (including mid put/consume) SHALL discard all pending updates with no partial write.

Verification (WIDTH=8, DEPTH=3)
REQ-032 Put 0x11, 0x22, 0x33 on consecutive cycles -> slots {0x11,0x22,0x33}, valid 3'b111, count=3, full=1.
REQ-033 From full, put 0x44 alone -> slots unchanged, overflow=1; then op_en with op_count=2 and put 0x55 together -> slots {0x33,0x55,0x00}, count=2, overflow stays 1.
REQ-034 With count=1, op_en with op_count=3 -> op_err=1 for exactly one cycle, op_ready=0, state unchanged.
REQ-035 With count=2 and overflow=1, clear together with put and op_en -> count=0, all slots 0, overflow=0, no op_err.
REQ-036 Assert reset between edges with count=3 -> outputs go to reset values before the next edge; a put on the first edge after release -> count=1.
REQ-037 Random put/op/clear stream of at least 10k cycles checked against a reference queue model -> zero mismatches; REQ-028 holds every cycle.
